// File: rtl/intc8008_pkg.sv
// rtl/intc8008_pkg.sv - T-state codes, FSM state type and RST opcode helper
package intc8008_pkg;

  // T-state codes as seen on the bit-reversed {S0,S1,S2} state bus
  localparam logic [2:0] S_T1      = 3'b010;
  localparam logic [2:0] S_T1I     = 3'b011;
  localparam logic [2:0] S_T2      = 3'b001;
  localparam logic [2:0] S_WAIT    = 3'b000;
  localparam logic [2:0] S_T3      = 3'b100;
  localparam logic [2:0] S_STOPPED = 3'b110;
  localparam logic [2:0] S_T4      = 3'b111;
  localparam logic [2:0] S_T5      = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } fsm_state_t;

  // RST n opcode jammed onto the data bus during the acknowledge cycle
  function automatic logic [7:0] rst_op(input logic [2:0] vec);
    return {2'b00, vec, 3'b101};
  endfunction

endpackage

// File: rtl/intc8008_src.sv
// rtl/intc8008_src.sv - one interrupt source: synchroniser, edge/level conditioning, pending bit
module intc8008_src #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_in,
  input  logic grant_clr,
  output logic pending
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic armed_q, armed_d;
  logic rise;

  // Next-state for synchroniser, edge latch and level re-arm; a new edge beats a same-cycle grant
  always_comb begin
    sync1_d = src_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    pend_d  = rise | (pend_q & ~grant_clr);
    armed_d = ~sync2_q | (armed_q & ~grant_clr);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
    end
  end

  // Level sources request only once per high period until the line drops
  assign pending = EDGE ? pend_q : (sync2_q & armed_q);

endmodule

// File: rtl/intc8008.sv
// rtl/intc8008.sv - prioritised maskable 8008 interrupt controller; INTC_STARTUP_EN adds a one-shot startup RST
module intc8008 #(
  parameter int                 NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = 4'b1111,
  parameter logic [NUM_SRC-1:0] MASK_RESET  = 4'b1111,
  parameter logic [2:0]         STARTUP_VEC = 3'd0
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               clk2,
  input  logic               sync,
  input  logic [2:0]         state,
  input  logic [NUM_SRC-1:0] src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               int_req,
  output logic [7:0]         int_code,
  output logic               ack_cycle,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);
  import intc8008_pkg::*;

  logic               clk2_q, clk2_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  fsm_state_t         fsm_q, fsm_d;
  logic               int_req_q, int_req_d;
  logic [7:0]         int_code_q, int_code_d;
  logic               ack_q, ack_d;
  logic               fall2;
  logic [NUM_SRC-1:0] req_vec, win_grant, grant;
  logic               win_found;
  logic [2:0]         win_vec;
`ifdef INTC_STARTUP_EN
  logic               startup_q, startup_d;
`else
  logic [2:0]         unused_startup_vec;
  assign unused_startup_vec = STARTUP_VEC;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intc8008_src #(.EDGE(EDGE_MASK[g])) u_src (
      .clk      (sys_clk),
      .rst_n    (reset_n),
      .src_in   (src[g]),
      .grant_clr(grant[g]),
      .pending  (pending[g])
    );
  end

  // Lowest-index enabled pending source, using the mask as it stood before any same-cycle write
  always_comb begin
    req_vec   = pending & mask_q;
    win_found = 1'b0;
    win_vec   = 3'd0;
    win_grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_vec[i] && !win_found) begin
        win_found    = 1'b1;
        win_vec      = 3'(i);
        win_grant[i] = 1'b1;
      end
    end
  end

  // Acknowledge FSM; every CPU-facing decision is taken on the clk2 falling-edge strobe
  always_comb begin
    clk2_d     = clk2;
    fall2      = clk2_q & ~clk2;
    mask_d     = mask_we ? mask_wdata : mask_q;
    fsm_d      = fsm_q;
    int_req_d  = int_req_q;
    int_code_d = int_code_q;
    ack_d      = ack_q;
    grant      = '0;
`ifdef INTC_STARTUP_EN
    startup_d  = startup_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (fall2 && !sync) begin
`ifdef INTC_STARTUP_EN
          if (startup_q && state == S_STOPPED) begin
            startup_d  = 1'b0;
            int_req_d  = 1'b1;
            int_code_d = rst_op(STARTUP_VEC);
            fsm_d      = ST_REQ;
          end else
`endif
          if (win_found) begin
            grant      = win_grant;
            int_req_d  = 1'b1;
            int_code_d = rst_op(win_vec);
            fsm_d      = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (fall2 && state == S_T1I) begin
          int_req_d = 1'b0;
          fsm_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        if (fall2 && state == S_T1I && sync) begin
          ack_d = 1'b1;
        end else if (fall2 && state == S_T3 && !sync) begin
          ack_d = 1'b0;
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers; reset is asynchronous so a mid-acknowledge reset releases the bus at once
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      clk2_q     <= 1'b0;
      mask_q     <= MASK_RESET;
      fsm_q      <= ST_IDLE;
      int_req_q  <= 1'b0;
      int_code_q <= 8'h00;
      ack_q      <= 1'b0;
`ifdef INTC_STARTUP_EN
      startup_q  <= 1'b1;
`endif
    end else begin
      clk2_q     <= clk2_d;
      mask_q     <= mask_d;
      fsm_q      <= fsm_d;
      int_req_q  <= int_req_d;
      int_code_q <= int_code_d;
      ack_q      <= ack_d;
`ifdef INTC_STARTUP_EN
      startup_q  <= startup_d;
`endif
    end
  end

  assign int_req   = int_req_q;
  assign int_code  = int_code_q;
  assign ack_cycle = ack_q;
  assign mask      = mask_q;

endmodule

// File: doc/intc8008.md
# intc8008

Parametrised interrupt controller for the 8008 memory/peripheral system on TangNano20K. It replaces the fixed three-source interrupt logic with N prioritised, maskable sources. Each source can be edge- or level-triggered and maps to its own RST vector. It tracks the CPU's T1I/T3 acknowledge sequence on the single `sys_clk` domain and hands the data-bus mux a ready-made RST opcode plus an ack-cycle flag.

## Interface
- `NUM_SRC`, 4, number of sources, 1..8; source i uses vector i.
- `EDGE_MASK`, 4'b1111, bit i = 1: source i is rising-edge; bit i = 0: source i is level-high.
- `MASK_RESET`, 4'b1111, enable-mask value after reset.
- `STARTUP_VEC`, 3'd0, RST vector of the startup interrupt.
- `sys_clk`  in  1  system clock, 27 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk2`  in  1  CPU phase-2 clock, a register output in the `sys_clk` domain; no synchroniser.
- `sync`  in  1  CPU SYNC.
- `state`  in  3  T-state code, already bit-reversed to {S0,S1,S2}.
- `src`  in  NUM_SRC  raw request lines, asynchronous.
- `mask_we`  in  1  one-cycle write strobe for the enable mask.
- `mask_wdata`  in  NUM_SRC  new enable mask.
- `int_req`  out  1  drives the CPU INTERRUPT pin.
- `int_code`  out  8  opcode for the acknowledge cycle, {2'b00, vec, 3'b101}.
- `ack_cycle`  out  1  high while the data-bus mux must drive `int_code` instead of memory.
- `pending`  out  NUM_SRC  live pending bits, for CSR readback.
- `mask`  out  NUM_SRC  current enable mask.

## Operation
- `src` passes through a 2-flop synchroniser.
- **Edge source:**
  - A rising edge of the synchronised value sets `pending[i]`.
  - Granting source i clears `pending[i]`.
  - If the set and the clear land in the same cycle, the set wins and the new edge is kept.
- **Level source:**
  - `pending[i]` = synchronised `src[i]` & `armed[i]`.
  - A grant clears `armed[i]`.
  - `armed[i]` sets again on any cycle where synchronised `src[i]` is 0.
- **Mask:** masked pending bits stay latched and fire once unmasked. `mask_we` updates the mask on the next edge.
- **Strobe:** `fall2` = previous `clk2` & ~`clk2`, one `sys_clk` cycle wide. All CPU-facing decisions happen only on `fall2`.
- **FSM states:**
  - IDLE:
    - On `fall2` & ~`sync`, arbitrate over `pending & mask`, lowest index wins.
    - A winner sets `int_req` = 1, latches `int_code`, clears that source's pending/armed bit and moves to REQ.
  - REQ: on `fall2` with `state` == T1I (3'b011), clear `int_req` and move to ACK.
  - ACK:
    - On `fall2` with T1I & `sync`, set `ack_cycle` = 1.
    - On `fall2` with T3 (3'b100) & ~`sync`, clear `ack_cycle` and move to IDLE.
- Arbitration uses the mask value held before any same-cycle `mask_we`.
- While in REQ or ACK, no new grant is made; new events only accumulate in `pending`.
- `int_code` holds its last value until the next grant.

## Timing
- **Reset values** (immediate on `reset_n` low, including mid-acknowledge):
  - `int_req` = 0, `ack_cycle` = 0, `int_code` = 8'h00.
  - `pending` = 0, `armed` = all 1s, `mask` = `MASK_RESET`, FSM = IDLE, startup flag = 1.
- `src` edge to `pending` visible: 3 `sys_clk` cycles (2 synchroniser stages + 1 edge detect).
- `pending` to `int_req`: at the next `fall2` with ~`sync`, at most one CPU clock cycle (54 `sys_clk` at 500 kHz).
- `int_req` stays high until the CPU reaches T1I. There is no timeout.
- `int_req`, `int_code` and `ack_cycle` are registered; no combinational path runs from inputs to them.

## Configuration
- `INTC_STARTUP_EN`, defined:
  - After reset, the first `fall2` in IDLE with ~`sync` and `state` == STOPPED (3'b110) raises `int_req` with vector `STARTUP_VEC`.
  - This request has priority over every source and ignores the mask.
  - It fires once per reset.
- `INTC_STARTUP_EN`, undefined: no startup request is generated; the startup flag logic is absent.

## Structure
- Package `intc8008_pkg`:
  - T-state codes S_T1, S_T1I, S_T2, S_WAIT, S_T3, S_STOPPED, S_T4, S_T5.
  - FSM state enum.
  - Function `rst_op(vec)` returning {2'b00, vec, 3'b101}.
- Sub-module `intc8008_src`, one instance per source:
  - Ports: synchroniser, edge/level conditioning and the pending/armed bits.
  - Parameter: `EDGE`.
  - Inputs: `grant_clr`.
  - Output: `pending`.

## Test plan
- Startup (macro defined): release reset, drive `state` = STOPPED with ~`sync` -> `int_req` = 1 at the next `fall2`; `int_code` = 8'h05. T1I then T3 -> `ack_cycle` high from T1I&`sync` to T3&~`sync`; `int_req` low after T1I.
- Priority: edges on `src[2]` and `src[1]` in the same cycle -> `int_code` = 8'h0D (RST1). After that acknowledge completes -> `int_code` = 8'h15 (RST2).
- Mask: `mask` = 4'b1110, pulse `src[0]` -> no request and `pending[0]` = 1. Write `mask` = 4'b1111 -> request with `int_code` = 8'h05.
- Level re-arm: `EDGE_MASK` bit 3 = 0, hold `src[3]` high through the acknowledge -> exactly one request (8'h1D). Drop and raise `src[3]` -> a second request.
- Collision: an edge on `src[1]` in the same cycle its grant clears `pending[1]` -> `pending[1]` = 1 afterwards.
- Reset mid-ACK: assert `reset_n` low while `ack_cycle` = 1 -> `ack_cycle`, `int_req` and `pending` are 0 immediately.
